// File: rtl/serial_pkg.sv
// Shared definitions for the serial line transmitter and its future receiver.
package serial_pkg;

    // Frame sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Line level while nothing is being sent, and the level of the start bit.
    localparam logic TX_IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL   = 1'b0;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-rate divider: pulses tick once every CLKS_PER_BIT cycles, counting
// from the cycle after clear. Also reused on boards to pace slow LED output.
module bit_tick_gen
    import serial_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_r;

    // Cycle counter: restarts on clear, wraps to zero after its terminal value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // The last cycle of each bit period is the tick; decoded from the register only.
    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/serial_bit_tx.sv
// Parallel-in, serial-out transmitter: start bit (low), DATA_W data bits LSB
// first, stop bit (high), each held for CLKS_PER_BIT cycles. All outputs registered.
module serial_bit_tx
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BW = cnt_width(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    tx_state_t         state_r,  state_s;
    logic [DATA_W-1:0] shreg_r,  shreg_s;
    logic [BW-1:0]     bitcnt_r, bitcnt_s;
    logic              tx_r,     tx_s;
    logic              busy_r,   busy_s;
    logic              done_r,   done_s;
    logic              clear_s;
    logic              tick_s;
    logic [DATA_W-1:0] shifted_s;

    bit_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .clear (clear_s),
        .tick  (tick_s)
    );

    assign shifted_s = shreg_r >> 1;

    // Next-state and next-output logic; outputs are computed here and registered below.
    always_comb begin
        state_s  = state_r;
        shreg_s  = shreg_r;
        bitcnt_s = bitcnt_r;
        tx_s     = tx_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        clear_s  = 1'b0;
        case (state_r)
            IDLE: begin
                tx_s   = TX_IDLE_LEVEL;
                busy_s = 1'b0;
                if (start) begin
                    // Capture the word now; later data_in changes cannot touch this frame.
                    shreg_s  = data_in;
                    bitcnt_s = '0;
                    clear_s  = 1'b1;
                    state_s  = START;
                    tx_s     = START_LEVEL;
                    busy_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    state_s = DATA;
                    tx_s    = shreg_r[0];
                end else begin
                    tx_s = START_LEVEL;
                end
            end
            DATA: begin
                if (tick_s) begin
                    if (bitcnt_r == LAST_BIT) begin
                        state_s  = STOP;
                        bitcnt_s = '0;
                        tx_s     = TX_IDLE_LEVEL;
                    end else begin
                        shreg_s  = shifted_s;
                        bitcnt_s = bitcnt_r + BW'(1);
                        tx_s     = shifted_s[0];
                    end
                end else begin
                    tx_s = shreg_r[0];
                end
            end
            STOP: begin
                tx_s = TX_IDLE_LEVEL;
                if (tick_s) begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    busy_s = 1'b1;
                end
            end
            default: begin
                state_s  = IDLE;
                shreg_s  = '0;
                bitcnt_s = '0;
                tx_s     = TX_IDLE_LEVEL;
                busy_s   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame and returns the line high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            shreg_r  <= '0;
            bitcnt_r <= '0;
            tx_r     <= TX_IDLE_LEVEL;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            shreg_r  <= shreg_s;
            bitcnt_r <= bitcnt_s;
            tx_r     <= tx_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign tx   = tx_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Directed bench for serial_bit_tx: default build (8 bits, 4 clocks/bit) and a
// minimum-rate build (4 bits, 1 clock/bit).
module tb_serial_bit_tx;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx, busy, done;

    logic       start_m = 1'b0;
    logic [3:0] data_m = 4'h0;
    logic       tx_m, busy_m, done_m;

    int errors = 0;
    int checks = 0;

    serial_bit_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    serial_bit_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) u_dut_min (
        .clock   (clock),
        .reset   (reset),
        .start   (start_m),
        .data_in (data_m),
        .tx      (tx_m),
        .busy    (busy_m),
        .done    (done_m)
    );

    always #5 clock = ~clock;

    // Advance past the next rising edge; outputs then reflect that edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expected line level k cycles after the accepting edge (k=0) for the default build.
    function automatic logic exp_tx(input logic [7:0] d, input int k);
        int b;
        b = k / 4;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    // Sends one frame and checks cycles 0..41; optionally changes data_in / re-pulses start.
    task automatic run_frame(input string name, input logic [7:0] d,
                             input int chg_k, input int restart_k);
        int ndone;
        int nbusy;
        ndone = 0;
        nbusy = 0;
        data_in = d;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k <= 41; k++) begin
            if (k > 0) step();
            start = 1'b0;
            checks++;
            if (tx !== exp_tx(d, k)) begin
                errors++;
                $display("FAIL %s tx k=%0d got=%b exp=%b", name, k, tx, exp_tx(d, k));
            end
            checks++;
            if (busy !== (k < 40)) begin
                errors++;
                $display("FAIL %s busy k=%0d got=%b exp=%b", name, k, busy, (k < 40));
            end
            checks++;
            if (done !== (k == 40)) begin
                errors++;
                $display("FAIL %s done k=%0d got=%b exp=%b", name, k, done, (k == 40));
            end
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) ndone++;
            if (k == chg_k) data_in = 8'hFF;
            if (k == restart_k) start = 1'b1;
        end
        checks++;
        if (nbusy != 40) begin
            errors++;
            $display("FAIL %s busy_len got=%0d exp=40", name, nbusy);
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL %s done_count got=%0d exp=1", name, ndone);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle k=%0d got tx=%b busy=%b done=%b exp 1/0/0", k, tx, busy, done);
            end
            checks++;
            if (tx_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle_min k=%0d got tx=%b busy=%b done=%b exp 1/0/0", k, tx_m, busy_m, done_m);
            end
        end
    endtask

    task automatic test_single_frame();
        run_frame("single_a5", 8'hA5, -1, -1);
    endtask

    task automatic test_ignored_inputs();
        run_frame("ignored_3c", 8'h3C, 5, 12);
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_no_restart busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        d1 = -1;
        d2 = -1;
        data_in = 8'h01;
        start = 1'b1;
        step();
        for (int k = 0; k <= 90; k++) begin
            if (k > 0) step();
            if (done === 1'b1) begin
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
            if (d2 >= 0) start = 1'b0;
            if (k == 41) begin
                checks++;
                if (tx !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_second_start got tx=%b busy=%b exp 0/1", tx, busy);
                end
            end
            if (k == 45 || k == 49) begin
                checks++;
                if (tx !== (k == 45)) begin
                    errors++;
                    $display("FAIL b2b_second_data k=%0d got=%b exp=%b", k, tx, (k == 45));
                end
            end
        end
        checks++;
        if (d1 != 40) begin
            errors++;
            $display("FAIL b2b_done1 got=%0d exp=40", d1);
        end
        checks++;
        if (d2 != 81) begin
            errors++;
            $display("FAIL b2b_done2 got=%0d exp=81", d2);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_final_idle busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        int ndone;
        ndone = 0;
        data_in = 8'h00;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 17; k++) step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async got tx=%b busy=%b done=%b exp 1/0/0", tx, busy, done);
        end
        step();
        reset = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_no_done got done_count=%0d tx=%b exp 0/1", ndone, tx);
        end
        run_frame("after_reset_00", 8'h00, -1, -1);
    endtask

    task automatic test_min_rate();
        logic [7:0] exp_line;
        exp_line = 8'b1111_0010;
        data_m = 4'b1001;
        start_m = 1'b1;
        step();
        start_m = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            checks++;
            if (tx_m !== exp_line[k]) begin
                errors++;
                $display("FAIL min_rate tx k=%0d got=%b exp=%b", k, tx_m, exp_line[k]);
            end
            checks++;
            if (done_m !== (k == 6) || busy_m !== (k < 6)) begin
                errors++;
                $display("FAIL min_rate ctl k=%0d got done=%b busy=%b exp %b/%b", k, done_m, busy_m, (k == 6), (k < 6));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_ignored_inputs();
        test_back_to_back();
        test_reset_mid_frame();
        test_min_rate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
